uart_rx_ctrl: RTL and testbench

Controller that sequences and buffers the UART receiver datapath.
- Generates the oversampling strobe `s_ticks` that the receiver consumes, from a programmable divisor.
- Tracks per-frame parity status from the receiver's `correct_send` pulse.
- Pushes each completed frame plus its parity flag into a small first-word-fall-through FIFO, drained by a valid/ready consumer.
- Maintains sticky overrun and parity-error statistics for the host.

---
 rtl/uart_rx_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: baud tick generator, per-frame parity tracking,
// first-word-fall-through frame FIFO with a valid/ready drain, and sticky
// overrun / saturating parity-error statistics.
// Optional build macro UART_RX_CTRL_DROP_PERR_EN: when defined, frames with a
// parity error are counted but never enter the FIFO, and m_perr is tied low.
module uart_rx_ctrl #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                          clk,
    input  logic                          Reset,
    input  logic                          en,
    input  logic [DIV_W-1:0]              baud_div,
    output logic                          s_ticks,
    input  logic                          rx_done_tick,
    input  logic                          correct_send,
    input  logic [DATA_W-1:0]             rx_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATA_W-1:0]             m_data,
    output logic                          m_perr,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    output logic [CNT_W-1:0]              perr_count,
    input  logic                          clr_stats
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FullCount = CW'(FIFO_DEPTH);

    typedef enum logic {StWait, StGood} state_e;

    // ---------------- baud tick generator ----------------
    logic [DIV_W-1:0] tick_cnt_q, tick_cnt_d;
    logic             s_ticks_q, s_ticks_d;

    // Next tick count; a count at or above the divisor fires a tick and restarts.
    always_comb begin
        tick_cnt_d = '0;
        s_ticks_d  = 1'b0;
        if (en) begin
            if (tick_cnt_q >= baud_div) begin
                s_ticks_d = 1'b1;
            end else begin
                tick_cnt_d = tick_cnt_q + 1'b1;
            end
        end
    end

    // Tick counter and registered strobe.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            tick_cnt_q <= '0;
            s_ticks_q  <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            s_ticks_q  <= s_ticks_d;
        end
    end

    assign s_ticks = s_ticks_q;

    // ---------------- parity tracking FSM ----------------
    state_e state_q, state_d;
    logic   frame_done;
    logic   frame_perr;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!Reset) state_q <= StWait;
        else        state_q <= state_d;
    end

    // Every completed frame returns to WAIT; a good-parity pulse arms GOOD.
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = StWait;
        end else if (rx_done_tick) begin
            state_d = StWait;
        end else if (correct_send) begin
            state_d = StGood;
        end
    end

    // Frame completion and its parity verdict (a pulse in the done cycle counts).
    always_comb begin
        frame_done = en & rx_done_tick;
        frame_perr = ~((state_q == StGood) | correct_send);
    end

    // ---------------- frame FIFO ----------------
    logic [DATA_W-1:0] mem_data_q [FIFO_DEPTH];
`ifndef UART_RX_CTRL_DROP_PERR_EN
    logic              mem_perr_q [FIFO_DEPTH];
`endif
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic              push_req, push, pop, full, ovr_set;

    // Push/pop arbitration; a pop frees the slot a full-FIFO push needs.
    always_comb begin
        pop  = (count_q != '0) & m_ready;
        full = (count_q == FullCount);
`ifdef UART_RX_CTRL_DROP_PERR_EN
        push_req = frame_done & ~frame_perr;
`else
        push_req = frame_done;
`endif
        push    = push_req & (~full | pop);
        ovr_set = push_req & full & ~pop;
        count_d = count_q;
        if (push & ~pop)      count_d = count_q + 1'b1;
        else if (pop & ~push) count_d = count_q - 1'b1;
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_data_q[i] <= '0;
`ifndef UART_RX_CTRL_DROP_PERR_EN
                mem_perr_q[i] <= 1'b0;
`endif
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                mem_data_q[wr_ptr_q] <= rx_data;
`ifndef UART_RX_CTRL_DROP_PERR_EN
                mem_perr_q[wr_ptr_q] <= frame_perr;
`endif
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    assign m_valid    = (count_q != '0);
    assign m_data     = mem_data_q[rd_ptr_q];
    assign fifo_count = count_q;
`ifdef UART_RX_CTRL_DROP_PERR_EN
    assign m_perr = 1'b0;
`else
    assign m_perr = mem_perr_q[rd_ptr_q];
`endif

    // ---------------- statistics ----------------
    logic             overrun_q, overrun_d;
    logic [CNT_W-1:0] perr_count_q, perr_count_d;

    // Clear wins over a same-cycle set or increment; the count saturates.
    always_comb begin
        overrun_d    = overrun_q | ovr_set;
        perr_count_d = perr_count_q;
        if (frame_done && frame_perr && (perr_count_q != '1)) begin
            perr_count_d = perr_count_q + 1'b1;
        end
        if (clr_stats) begin
            overrun_d    = 1'b0;
            perr_count_d = '0;
        end
    end

    // Statistic registers.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            overrun_q    <= 1'b0;
            perr_count_q <= '0;
        end else begin
            overrun_q    <= overrun_d;
            perr_count_q <= perr_count_d;
        end
    end

    assign overrun    = overrun_q;
    assign perr_count = perr_count_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: a queue-based reference model checked every cycle,
// plus literal expectations at the key points of each directed scenario.
module tb_uart_rx_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        Reset;
    logic        en;
    logic [15:0] baud_div;
    logic        s_ticks;
    logic        rx_done_tick;
    logic        correct_send;
    logic [7:0]  rx_data;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_data;
    logic        m_perr;
    logic [2:0]  fifo_count;
    logic        overrun;
    logic [7:0]  perr_count;
    logic        clr_stats;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    uart_rx_ctrl dut (
        .clk          (clk),
        .Reset        (Reset),
        .en           (en),
        .baud_div     (baud_div),
        .s_ticks      (s_ticks),
        .rx_done_tick (rx_done_tick),
        .correct_send (correct_send),
        .rx_data      (rx_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_data       (m_data),
        .m_perr       (m_perr),
        .fifo_count   (fifo_count),
        .overrun      (overrun),
        .perr_count   (perr_count),
        .clr_stats    (clr_stats)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [8:0] q [$];
    int         m_cnt;
    bit         m_tick, m_good, m_ovr;
    int         m_pc;

    always @(posedge clk) begin
        int  pre;
        bit  pop, done, perr, wr;
        if (!Reset) begin
            q.delete();
            m_cnt = 0; m_tick = 0; m_good = 0; m_ovr = 0; m_pc = 0;
        end else begin
            pre  = q.size();
            pop  = (pre > 0) && m_ready;
            if (!en) begin
                m_cnt = 0; m_tick = 0;
            end else if (m_cnt >= int'(baud_div)) begin
                m_cnt = 0; m_tick = 1;
            end else begin
                m_cnt++; m_tick = 0;
            end
            done = en && rx_done_tick;
            perr = !(m_good || correct_send);
            if (!en || rx_done_tick) m_good = 0;
            else if (correct_send)   m_good = 1;
`ifdef UART_RX_CTRL_DROP_PERR_EN
            wr = done && !perr;
`else
            wr = done;
`endif
            if (pop) void'(q.pop_front());
            if (wr) begin
                if (pre < DEPTH || pop) q.push_back({perr, rx_data});
                else m_ovr = 1;
            end
            if (done && perr && m_pc < 255) m_pc++;
            if (clr_stats) begin
                m_ovr = 0; m_pc = 0;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("s_ticks", 32'(s_ticks), 32'(m_tick));
            check("m_valid", 32'(m_valid), 32'(q.size() != 0));
            check("fifo_count", 32'(fifo_count), 32'(q.size()));
            check("overrun", 32'(overrun), 32'(m_ovr));
            check("perr_count", 32'(perr_count), 32'(m_pc));
            if (q.size() != 0) begin
                check("m_data", 32'(m_data), 32'(q[0][7:0]));
`ifdef UART_RX_CTRL_DROP_PERR_EN
                check("m_perr", 32'(m_perr), 32'd0);
`else
                check("m_perr", 32'(m_perr), 32'(q[0][8]));
`endif
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic frame(input logic [7:0] d, input logic cs);
        rx_done_tick = 1'b1;
        rx_data      = d;
        correct_send = cs;
        cyc();
        rx_done_tick = 1'b0;
        correct_send = 1'b0;
    endtask

    task automatic drain_expect(input logic [7:0] d0, input logic [7:0] d1,
                                input logic [7:0] d2, input logic [7:0] d3);
        logic [7:0] exp [4];
        exp[0] = d0; exp[1] = d1; exp[2] = d2; exp[3] = d3;
        for (int i = 0; i < 4; i++) begin
            check("drain_order", 32'(m_data), 32'(exp[i]));
            m_ready = 1'b1;
            cyc();
        end
        m_ready = 1'b0;
        check("drain_empty", 32'(m_valid), 32'd0);
    endtask

    initial begin
        Reset = 1'b0; en = 1'b0; baud_div = 16'd3; rx_done_tick = 1'b0;
        correct_send = 1'b0; rx_data = 8'h00; m_ready = 1'b0; clr_stats = 1'b0;
        cyc();
        cyc();
        chk_en = 1'b1;
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_valid", 32'(m_valid), 32'd0);
        check("rst_data", 32'(m_data), 32'd0);
        check("rst_perr", 32'(m_perr), 32'd0);
        check("rst_tick", 32'(s_ticks), 32'd0);
        check("rst_ovr", 32'(overrun), 32'd0);
        check("rst_pcnt", 32'(perr_count), 32'd0);

        // Baud generator: divisor 3 -> every 4th cycle.
        Reset = 1'b1; en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cyc();
            check("tick_div3", 32'(s_ticks), 32'((i % 4) == 3));
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("tick_dis", 32'(s_ticks), 32'd0);
        end
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            check("tick_reen", 32'(s_ticks), 32'((i % 4) == 3));
        end
        baud_div = 16'd0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("tick_div0", 32'(s_ticks), 32'd1);
        end
        baud_div = 16'd7;
        for (int i = 0; i < 5; i++) cyc();
        baud_div = 16'd2;
        cyc();
        check("tick_lower", 32'(s_ticks), 32'd1);
        baud_div = 16'd3;

        // Good frame.
        correct_send = 1'b1;
        cyc();
        correct_send = 1'b0;
        frame(8'hA5, 1'b0);
        check("a5_valid", 32'(m_valid), 32'd1);
        check("a5_data", 32'(m_data), 32'hA5);
        check("a5_perr", 32'(m_perr), 32'd0);
        check("a5_count", 32'(fifo_count), 32'd1);
        m_ready = 1'b1;
        cyc();
        m_ready = 1'b0;
        check("a5_popped", 32'(m_valid), 32'd0);

        // Parity-error frame.
        frame(8'h3C, 1'b0);
        check("3c_pcnt", 32'(perr_count), 32'd1);
`ifdef UART_RX_CTRL_DROP_PERR_EN
        check("3c_dropped", 32'(fifo_count), 32'd0);
`else
        check("3c_count", 32'(fifo_count), 32'd1);
        check("3c_perr", 32'(m_perr), 32'd1);
        check("3c_data", 32'(m_data), 32'h3C);
        m_ready = 1'b1;
        cyc();
        m_ready = 1'b0;
`endif

        // Overflow: five frames into a depth-4 FIFO.
        for (int i = 1; i <= 5; i++) frame(8'(i), 1'b1);
        check("ovf_count", 32'(fifo_count), 32'd4);
        check("ovf_flag", 32'(overrun), 32'd1);
        drain_expect(8'h01, 8'h02, 8'h03, 8'h04);
        clr_stats = 1'b1;
        cyc();
        clr_stats = 1'b0;
        check("clr_ovr", 32'(overrun), 32'd0);
        check("clr_pcnt", 32'(perr_count), 32'd0);

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < 4; i++) frame(8'h11 + 8'(i), 1'b1);
        m_ready = 1'b1;
        frame(8'h15, 1'b1);
        m_ready = 1'b0;
        check("pp_count", 32'(fifo_count), 32'd4);
        check("pp_ovr", 32'(overrun), 32'd0);
        drain_expect(8'h12, 8'h13, 8'h14, 8'h15);

        // Clear coincident with a parity-error frame.
        clr_stats = 1'b1;
        frame(8'h77, 1'b0);
        clr_stats = 1'b0;
        check("clr_win", 32'(perr_count), 32'd0);
        m_ready = 1'b1;
        cyc();
        m_ready = 1'b0;

        // Saturation of the parity-error counter.
        m_ready = 1'b1;
        for (int i = 0; i < 260; i++) frame(8'(i), 1'b0);
        check("pcnt_sat", 32'(perr_count), 32'd255);
        cyc();
        cyc();
        m_ready = 1'b0;

        // Reset mid-activity: two entries held and FSM in GOOD.
        frame(8'h21, 1'b1);
        frame(8'h22, 1'b1);
        correct_send = 1'b1;
        cyc();
        correct_send = 1'b0;
        check("prerst_count", 32'(fifo_count), 32'd2);
        Reset = 1'b0;
        cyc();
        Reset = 1'b1;
        check("rst2_count", 32'(fifo_count), 32'd0);
        check("rst2_valid", 32'(m_valid), 32'd0);
        check("rst2_ovr", 32'(overrun), 32'd0);
        check("rst2_pcnt", 32'(perr_count), 32'd0);
        frame(8'h5A, 1'b0);
        check("rst2_pcnt1", 32'(perr_count), 32'd1);
`ifdef UART_RX_CTRL_DROP_PERR_EN
        check("rst2_drop", 32'(fifo_count), 32'd0);
`else
        check("rst2_perr", 32'(m_perr), 32'd1);
        check("rst2_data", 32'(m_data), 32'h5A);
`endif
        cyc();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
